// File: rtl/issue_hazard_ctrl.sv
// Issue-stage hazard controller: load/mul-div scoreboard, decode stall and mul/div sequencing.
// Optional stall-cycle counter is built when HAZARD_STALL_STATS_EN is defined.
module issue_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              DEC_VALID,
  input  logic [4:0]        DEC_RS1,
  input  logic [4:0]        DEC_RS2,
  input  logic [4:0]        DEC_RD,
  input  logic              DEC_WRITES_RD,
  input  logic              DEC_IS_LOAD,
  input  logic              DEC_IS_MULDIV,
  input  logic              FLUSH,
  input  logic              MD_DONE,
  output logic              STALL,
  output logic              ISSUE,
  output logic              MD_START,
  output logic              MD_BUSY,
  output logic [31:0]       BUSY_MASK,
  output logic [STAT_W-1:0] STALL_CYCLES
);

  // With LOAD_LAT=1 one dummy stage exists but is never written valid.
  localparam int unsigned NStg = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e       state_q, state_d;
  logic [4:0]      md_rd_q, md_rd_d;
  logic [NStg-1:0] ld_vld_q;
  logic [4:0]      ld_rd_q [NStg];
  logic [31:0]     ld_mask, md_mask, pend_mask;
  logic            hazard, ld_new;

  always_comb begin
    ld_mask = '0;
    for (int i = 0; i < NStg; i++) begin
      if (ld_vld_q[i]) ld_mask[ld_rd_q[i]] = 1'b1;
    end
    md_mask = '0;
    if (state_q == StBusy) md_mask[md_rd_q] = 1'b1;
  end

  // MD_DONE bypasses the mul/div entry for hazard purposes only.
  assign pend_mask = (ld_mask | (MD_DONE ? 32'd0 : md_mask)) & ~32'd1;
  assign BUSY_MASK = (ld_mask | md_mask) & ~32'd1;

  assign hazard = pend_mask[DEC_RS1] | pend_mask[DEC_RS2]
                | (DEC_WRITES_RD & pend_mask[DEC_RD])
                | (DEC_IS_MULDIV & (state_q == StBusy) & ~MD_DONE);

  always_comb begin
    STALL    = DEC_VALID & hazard & ~FLUSH;
    ISSUE    = DEC_VALID & ~hazard & ~FLUSH;
    MD_START = ISSUE & DEC_IS_MULDIV;
    MD_BUSY  = (state_q == StBusy);
  end

  always_comb begin
    state_d = state_q;
    md_rd_d = md_rd_q;
    unique case (state_q)
      StIdle: if (MD_START) state_d = StBusy;
      StBusy: if (MD_DONE) state_d = MD_START ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
    if (MD_START) md_rd_d = DEC_WRITES_RD ? DEC_RD : 5'd0;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= StIdle;
      md_rd_q <= '0;
    end else begin
      state_q <= state_d;
      md_rd_q <= md_rd_d;
    end
  end

  assign ld_new = (LOAD_LAT > 1) && ISSUE && DEC_IS_LOAD && DEC_WRITES_RD && (DEC_RD != 5'd0);

  // Load pipe shifts every cycle, independent of STALL.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ld_vld_q <= '0;
      for (int i = 0; i < NStg; i++) ld_rd_q[i] <= '0;
    end else begin
      ld_vld_q[0] <= ld_new;
      ld_rd_q[0]  <= DEC_RD;
      for (int i = 1; i < NStg; i++) begin
        ld_vld_q[i] <= ld_vld_q[i-1];
        ld_rd_q[i]  <= ld_rd_q[i-1];
      end
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      stall_cnt_q <= '0;
    end else if (STALL && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  assign STALL_CYCLES = stall_cnt_q;
`else
  assign STALL_CYCLES = '0;
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: directed vector table, hand sequences and a random run
// checked against a timestamp-based scoreboard model.
module tb_issue_hazard_ctrl;

  localparam int unsigned LoadLat = 2;
`ifdef HAZARD_STALL_STATS_EN
  localparam int unsigned StatsExp = 3;
`else
  localparam int unsigned StatsExp = 0;
`endif

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        d_valid, d_wr, d_ld, d_md, d_flush, d_done;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        STALL, ISSUE, MD_START, MD_BUSY;
  logic [31:0] BUSY_MASK, STALL_CYCLES;

  always #5 CLK = ~CLK;

  issue_hazard_ctrl #(.LOAD_LAT(LoadLat), .STAT_W(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .DEC_VALID(d_valid), .DEC_RS1(d_rs1), .DEC_RS2(d_rs2),
    .DEC_RD(d_rd), .DEC_WRITES_RD(d_wr), .DEC_IS_LOAD(d_ld), .DEC_IS_MULDIV(d_md),
    .FLUSH(d_flush), .MD_DONE(d_done), .STALL(STALL), .ISSUE(ISSUE), .MD_START(MD_START),
    .MD_BUSY(MD_BUSY), .BUSY_MASK(BUSY_MASK), .STALL_CYCLES(STALL_CYCLES)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: cycle at which each reg's load result becomes usable, plus mul/div ownership.
  int unsigned cyc = 0;
  int unsigned ld_ready [32];
  bit          md_own;
  logic [4:0]  md_reg;
  int unsigned stat_cnt;
  logic        exp_stall, exp_issue, exp_start, exp_busy;
  logic [31:0] exp_mask, exp_stat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic bit pend(input logic [4:0] r, input bit done);
    return (r != 0) && ((cyc < ld_ready[r]) || (md_own && md_reg == r && !done));
  endfunction

  task automatic calc_exp();
    bit haz;
    haz = pend(d_rs1, d_done) || pend(d_rs2, d_done) || (d_wr && pend(d_rd, d_done))
        || (d_md && md_own && !d_done);
    exp_stall = d_valid && haz && !d_flush;
    exp_issue = d_valid && !haz && !d_flush;
    exp_start = exp_issue && d_md;
    exp_busy  = md_own;
    exp_mask  = '0;
    for (int r = 1; r < 32; r++) exp_mask[r] = pend(5'(r), 1'b0);
`ifdef HAZARD_STALL_STATS_EN
    exp_stat = stat_cnt;
`else
    exp_stat = '0;
`endif
  endtask

  task automatic upd_model();
    if (!RSTN) begin
      for (int r = 0; r < 32; r++) ld_ready[r] = 0;
      md_own = 0; md_reg = 0; stat_cnt = 0;
    end else begin
      if (exp_issue && d_ld && d_wr && d_rd != 0) ld_ready[d_rd] = cyc + LoadLat;
      if (md_own && d_done) md_own = 0;
      if (exp_start) begin md_own = 1; md_reg = d_wr ? d_rd : 5'd0; end
      if (exp_stall && stat_cnt != 32'hFFFF_FFFF) stat_cnt++;
    end
    cyc++;
  endtask

  task automatic half(input bit chk);
    @(negedge CLK);
    calc_exp();
    if (chk) begin
      check("stall", STALL, exp_stall);
      check("issue", ISSUE, exp_issue);
      check("md_start", MD_START, exp_start);
      check("md_busy", MD_BUSY, exp_busy);
      check("busy_mask", BUSY_MASK, exp_mask);
      check("stall_cycles", STALL_CYCLES, exp_stat);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    upd_model();
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic w, input logic l, input logic m,
                     input logic f, input logic dn);
    d_valid = v; d_rs1 = r1; d_rs2 = r2; d_rd = rd; d_wr = w;
    d_ld = l; d_md = m; d_flush = f; d_done = dn;
  endtask

  typedef struct {
    logic v; logic [4:0] r1, r2, rd; logic w, l, m, f, dn;
    logic e_stall, e_issue, e_start, e_busy; logic [31:0] e_mask;
  } vec_t;
  vec_t tbl [13];

  initial begin
    for (int r = 0; r < 32; r++) ld_ready[r] = 0;
    md_own = 0; md_reg = 0; stat_cnt = 0;
    //         v  rs1 rs2 rd  w  l  m  f  dn  stall issue start busy mask
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0};        // reset state
    tbl[1]  = '{1, 1, 0, 5, 1, 1, 0, 0, 0,  0, 1, 0, 0, 32'h0};        // lw x5
    tbl[2]  = '{1, 5, 1, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0, 32'h20};       // add x6,x5,x1 stalls
    tbl[3]  = '{1, 5, 1, 6, 1, 0, 0, 0, 0,  0, 1, 0, 0, 32'h0};        // then issues
    tbl[4]  = '{1, 2, 0, 0, 1, 1, 0, 0, 0,  0, 1, 0, 0, 32'h0};        // lw x0
    tbl[5]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 32'h0};        // add x1,x0,x0
    tbl[6]  = '{1, 1, 0, 5, 1, 1, 0, 0, 0,  0, 1, 0, 0, 32'h0};        // lw x5
    tbl[7]  = '{1, 5, 0, 6, 1, 0, 0, 1, 0,  0, 0, 0, 0, 32'h20};       // flushed dependent
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0};
    tbl[9]  = '{1, 1, 2, 7, 1, 0, 1, 0, 0,  0, 1, 1, 0, 32'h0};        // div x7
    tbl[10] = '{1, 7, 0, 8, 1, 0, 0, 0, 0,  1, 0, 0, 1, 32'h80};       // add x8,x7,x0
    tbl[11] = '{1, 7, 0, 8, 1, 0, 0, 0, 1,  0, 1, 0, 1, 32'h80};       // MD_DONE bypass
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0};

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    RSTN = 1'b0;
    repeat (2) begin half(0); adv(); end
    RSTN = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drv(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].w, tbl[i].l, tbl[i].m,
          tbl[i].f, tbl[i].dn);
      half(0);
      check($sformatf("tbl%0d_stall", i), STALL, tbl[i].e_stall);
      check($sformatf("tbl%0d_issue", i), ISSUE, tbl[i].e_issue);
      check($sformatf("tbl%0d_start", i), MD_START, tbl[i].e_start);
      check($sformatf("tbl%0d_busy", i), MD_BUSY, tbl[i].e_busy);
      check($sformatf("tbl%0d_mask", i), BUSY_MASK, tbl[i].e_mask);
      adv();
    end

    // Div occupancy: dependent held 10 cycles, issues on MD_DONE.
    drv(1, 1, 2, 7, 1, 0, 1, 0, 0); half(1); check("div_start", MD_START, 1); adv();
    drv(1, 7, 0, 8, 1, 0, 0, 0, 0);
    repeat (10) begin half(1); check("div_dep_stall", STALL, 1); adv(); end
    drv(1, 7, 0, 8, 1, 0, 0, 0, 1); half(1); check("div_done_issue", ISSUE, 1); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); half(1); check("div_busy_clear", MD_BUSY, 0); adv();

    // Structural stall and back-to-back mul on the MD_DONE cycle.
    drv(1, 1, 0, 3, 1, 0, 1, 0, 0); half(1); adv();
    drv(1, 2, 0, 4, 1, 0, 1, 0, 0);
    repeat (3) begin half(1); check("mul2_struct_stall", STALL, 1); adv(); end
    drv(1, 2, 0, 4, 1, 0, 1, 0, 1); half(1); check("mul2_start", MD_START, 1); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); half(1);
    check("mul2_busy", MD_BUSY, 1); check("mul2_rd", BUSY_MASK, 32'h10); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1); half(1); adv();

    // Reset mid-op drops ownership; later MD_DONE is ignored.
    drv(1, 1, 0, 9, 1, 0, 1, 0, 0); half(1); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); half(1); adv();
    RSTN = 1'b0; half(1); adv(); RSTN = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1); half(1);
    check("rst_mask", BUSY_MASK, 0); check("rst_busy", MD_BUSY, 0); adv();
    drv(1, 2, 9, 2, 1, 0, 0, 0, 0); half(1); check("rst_dep_issue", ISSUE, 1); adv();

    // Stall counter: exactly 3 stall cycles after reset.
    RSTN = 1'b0; drv(0, 0, 0, 0, 0, 0, 0, 0, 0); half(1); adv(); RSTN = 1'b1;
    drv(1, 1, 0, 3, 1, 0, 1, 0, 0); half(1); adv();
    drv(1, 3, 0, 4, 1, 0, 0, 0, 0); repeat (3) begin half(1); adv(); end
    drv(1, 3, 0, 4, 1, 0, 0, 0, 1); half(1); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); half(1); check("stats", STALL_CYCLES, StatsExp); adv();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned k;
      RSTN = ($urandom_range(0, 299) != 0);
      k = $urandom_range(0, 7);
      drv($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, k < 2, k == 2,
          $urandom_range(0, 9) == 0,
          md_own ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0));
      half(1);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
Issue-stage scheduler between the decoder and the execute stage. It tracks in-flight destination registers in a scoreboard for two sources: fixed-latency loads and one outstanding multi-cycle mul/div. It stalls decode on RAW/WAW hazards and sequences the shared mul/div unit with a start pulse and a done handshake. ALU results are fully bypassed, so ALU ops never create pending entries.

Parameters:
LOAD_LAT, 2, cycles from load issue to earliest dependent issue; legal range 1..8; LOAD_LAT=1 means loads never stall.
STAT_W, 32, width of the optional stall-cycle counter.

Ports:
CLK  input  1  clock, all state on posedge.
RSTN  input  1  synchronous active-low reset.
DEC_VALID  input  1  decoded instruction present this cycle.
DEC_RS1  input  5  source reg 1; 0 means unused.
DEC_RS2  input  5  source reg 2; 0 means unused.
DEC_RD  input  5  destination reg.
DEC_WRITES_RD  input  1  instruction writes DEC_RD.
DEC_IS_LOAD  input  1  instruction is lb/lh/lw/lbu/lhu.
DEC_IS_MULDIV  input  1  instruction is mul/mulh/mulhsu/mulhu/div/divu/rem/remu.
FLUSH  input  1  kill the decode-stage instruction this cycle (branch/jump redirect).
MD_DONE  input  1  mul/div unit result written back this cycle.
STALL  output  1  hold decode/fetch this cycle (combinational).
ISSUE  output  1  instruction accepted into execute this cycle (combinational).
MD_START  output  1  one-cycle start pulse to the mul/div unit (combinational).
MD_BUSY  output  1  mul/div unit owned by an outstanding op (registered).
BUSY_MASK  output  32  registered pending-write mask; bit r is set if reg r is pending; bit 0 always 0.
STALL_CYCLES  output  STAT_W  stall counter (see Optional Feature).

Behaviour:
- Reset (RSTN=0 at posedge): load pipe cleared, FSM to IDLE, md_rd=0, BUSY_MASK=0, MD_BUSY=0, STALL_CYCLES=0. Combinational outputs follow the cleared state. Reset mid mul/div drops ownership. A later MD_DONE seen in IDLE is ignored.
- Load pipe: LOAD_LAT-1 stages of {valid, rd}, shifting every cycle regardless of STALL. A load issued at cycle t enters stage 1 at t+1. A reg is load-pending while any valid stage holds it. A dependent op stalls t+1..t+LOAD_LAT-1 and issues at t+LOAD_LAT.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE -> BUSY when ISSUE & DEC_IS_MULDIV; md_rd is captured (0 if DEC_WRITES_RD=0).
  - BUSY -> IDLE on MD_DONE.
  - BUSY -> BUSY (md_rd reloaded) if MD_DONE and a new mul/div issues in the same cycle.
  - md-pending(r) = BUSY & md_rd==r & r!=0 & ~MD_DONE. MD_DONE bypasses, so a dependent op issues in the same cycle as MD_DONE.
- Hazard, evaluated when DEC_VALID=1:
  - RAW: DEC_RS1!=0 and DEC_RS1 pending, or DEC_RS2!=0 and DEC_RS2 pending.
  - WAW: DEC_WRITES_RD & DEC_RD!=0 & DEC_RD pending.
  - Structural: DEC_IS_MULDIV & BUSY & ~MD_DONE.
- STALL = DEC_VALID & hazard & ~FLUSH. FLUSH overrides STALL, because a killed instruction must not hold the pipe.
- ISSUE = DEC_VALID & ~hazard & ~FLUSH.
- MD_START = ISSUE & DEC_IS_MULDIV.
- Load entry written only when ISSUE & DEC_IS_LOAD & DEC_WRITES_RD & DEC_RD!=0.
- FLUSH never cancels older in-flight loads or mul/div; their scoreboard entries persist until they retire.
- BUSY_MASK = OR of load stages and the md_rd bit from registered state (MD_DONE not bypassed). It updates one cycle after issue/retire.
- DEC_IS_LOAD and DEC_IS_MULDIV both high: illegal, behaviour undefined.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- Defined: STALL_CYCLES increments on every cycle with STALL=1, saturates at all-ones, and clears on reset.
- Undefined: the counter logic is not built and STALL_CYCLES is tied to 0. The port exists in both builds.

Test Plan:
- Load-use: issue lw x5 (LOAD_LAT=2), next cycle add x6,x5,x1 -> STALL=1 for exactly 1 cycle, add ISSUE=1 on the 2nd cycle; BUSY_MASK[5]=1 for 1 cycle.
- Div occupancy: issue div x7 -> MD_START=1, MD_BUSY=1. Hold add x8,x7,x0 for 10 cycles with STALL=1. Assert MD_DONE -> add issues that same cycle; MD_BUSY=0 next cycle.
- Structural + back-to-back: mul x3 in flight, mul x4 stalls until MD_DONE. On the MD_DONE cycle MD_START=1, MD_BUSY stays 1, and md_rd becomes 4.
- x0 and flush: lw x0 then add x1,x0,x0 -> no stall. Dependent op with FLUSH=1 -> STALL=0, ISSUE=0, and the load entry still present in BUSY_MASK.
- Reset mid-op: div x9 in flight, RSTN=0 for one cycle -> BUSY_MASK=0, MD_BUSY=0. A later MD_DONE is ignored, and add x2,x9,x0 issues immediately.
- Stats build (HAZARD_STALL_STATS_EN): 3 stall cycles -> STALL_CYCLES=3. Non-stats build: reads 0.
